// File: rtl/serial_subtractor_ctrl_pkg.sv
// serial_subtractor_ctrl_pkg: state encodings and defaults shared by serial-arithmetic controllers
package serial_subtractor_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// serial_subtractor_ctrl_if: start/done/ack request bus between requester and subtractor
interface serial_subtractor_ctrl_if import serial_subtractor_ctrl_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic ack;
  logic ready;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic borrow_out;
  modport master (output start, a, b, ack, input ready, busy, done, diff, borrow_out);
  modport slave (input start, a, b, ack, output ready, busy, done, diff, borrow_out);
endinterface

// File: rtl/serial_subtractor_ctrl_fs.sv
// serial_subtractor_ctrl_fs: 1-bit full subtractor built from two half subtractors
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);
  assign d = x ^ y;
  assign b = ~x & y;
endmodule

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;
  half_subtractor u_hs0 (.x(x), .y(y), .d(d1), .b(b1));
  half_subtractor u_hs1 (.x(d1), .y(bin), .d(d), .b(b2));
  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial a-b controller, one bit per clock, start/done/ack handshake
module serial_subtractor_ctrl import serial_subtractor_ctrl_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic clk,
  input logic rst,
  serial_subtractor_ctrl_if.slave bus
);
  state_t st;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
  logic [WIDTH:0] sh;
  logic [CNT_W-1:0] cnt;
  logic brw, d, bout, last;
  full_subtractor u_fs (.x(a_sh[0]), .y(b_sh[0]), .bin(brw), .d(d), .bout(bout));
  // new bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
  assign sh = {d, diff_sh} >> 1;
  assign last = cnt == CNT_W'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst || st == state_t'(2'd3)) begin
      st <= ST_IDLE;
      bus.ready <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.borrow_out <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      diff_sh <= '0;
      brw <= 1'b0;
      cnt <= '0;
    end else begin
      case (st)
        ST_IDLE: if (bus.start) begin
          st <= ST_RUN;
          bus.ready <= 1'b0;
          bus.busy <= 1'b1;
          a_sh <= bus.a;
          b_sh <= bus.b;
          diff_sh <= '0;
          brw <= 1'b0;
          cnt <= '0;
        end
        ST_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          diff_sh <= sh[WIDTH-1:0];
          brw <= bout;
          cnt <= last ? '0 : cnt + CNT_W'(1);
          if (last) begin
            st <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.diff <= sh[WIDTH-1:0];
            bus.borrow_out <= bout;
          end
        end
        ST_DONE: if (bus.ack) begin
          st <= ST_IDLE;
          bus.done <= 1'b0;
          bus.ready <= 1'b1;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: directed vectors for WIDTH=8 and WIDTH=1 controllers
module tb_serial_subtractor_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  serial_subtractor_ctrl_if #(.WIDTH(8)) b8 ();
  serial_subtractor_ctrl_if #(.WIDTH(1)) b1 ();
  serial_subtractor_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  serial_subtractor_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    b8.a = a;
    b8.b = b;
    b8.start = 1'b1;
    @(posedge clk);
    #1 b8.start = 1'b0;
  endtask

  task automatic wait8(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!b8.done && n < 20);
  endtask

  task automatic ack8();
    b8.ack = 1'b1;
    @(posedge clk);
    #1 b8.ack = 1'b0;
  endtask

  task automatic full8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] d, input logic bo);
    int n;
    start8(a, b);
    chk({tag, "_busy"}, 32'(b8.busy), 1);
    wait8(n);
    chk({tag, "_lat"}, 32'(n), 8);
    chk({tag, "_diff"}, 32'(b8.diff), 32'(d));
    chk({tag, "_bo"}, 32'(b8.borrow_out), 32'(bo));
    ack8();
    chk({tag, "_ready"}, 32'(b8.ready), 1);
    chk({tag, "_done"}, 32'(b8.done), 0);
  endtask

  task automatic full1(input string tag, input logic a, input logic b, input logic d, input logic bo);
    b1.a = a;
    b1.b = b;
    b1.start = 1'b1;
    @(posedge clk);
    #1 b1.start = 1'b0;
    @(posedge clk);
    #1 chk({tag, "_done"}, 32'(b1.done), 1);
    chk({tag, "_diff"}, 32'(b1.diff), 32'(d));
    chk({tag, "_bo"}, 32'(b1.borrow_out), 32'(bo));
    b1.ack = 1'b1;
    @(posedge clk);
    #1 b1.ack = 1'b0;
    chk({tag, "_ready"}, 32'(b1.ready), 1);
  endtask

  initial begin
    int n;
    b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.ack = 1'b0;
    b1.start = 1'b0; b1.a = '0; b1.b = '0; b1.ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("rst_ready", 32'(b8.ready), 1);
    chk("rst_busy", 32'(b8.busy), 0);
    chk("rst_done", 32'(b8.done), 0);
    chk("rst_diff", 32'(b8.diff), 0);
    chk("rst_bo", 32'(b8.borrow_out), 0);
    chk("rst_ready1", 32'(b1.ready), 1);
    rst = 1'b0;
    full8("t5a3c", 8'h5A, 8'h3C, 8'h1E, 1'b0);
    full8("t0001", 8'h00, 8'h01, 8'hFF, 1'b1);
    full8("tffff", 8'hFF, 8'hFF, 8'h00, 1'b0);
    // restart attempt mid-run must be ignored
    start8(8'h5A, 8'h3C);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    b8.a = 8'h11; b8.b = 8'h22; b8.start = 1'b1;
    @(posedge clk);
    #1 b8.start = 1'b0;
    wait8(n);
    chk("ign_lat", 32'(n + 3), 8);
    chk("ign_diff", 32'(b8.diff), 'h1E);
    chk("ign_bo", 32'(b8.borrow_out), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("hold_done", 32'(b8.done), 1);
      chk("hold_diff", 32'(b8.diff), 'h1E);
    end
    b8.a = 8'h00; b8.b = 8'h01; b8.ack = 1'b1; b8.start = 1'b1;
    @(posedge clk);
    #1 b8.ack = 1'b0; b8.start = 1'b0;
    chk("ackst_ready", 32'(b8.ready), 1);
    chk("ackst_done", 32'(b8.done), 0);
    @(posedge clk);
    #1 chk("ackst_busy", 32'(b8.busy), 0);
    chk("ackst_diff", 32'(b8.diff), 'h1E);
    // reset during the fourth run cycle discards the partial result
    start8(8'h5A, 8'h3C);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_ready", 32'(b8.ready), 1);
    chk("mrst_busy", 32'(b8.busy), 0);
    chk("mrst_done", 32'(b8.done), 0);
    chk("mrst_diff", 32'(b8.diff), 0);
    chk("mrst_bo", 32'(b8.borrow_out), 0);
    full8("t8001", 8'h80, 8'h01, 8'h7F, 1'b0);
    full1("w00", 1'b0, 1'b0, 1'b0, 1'b0);
    full1("w01", 1'b0, 1'b1, 1'b1, 1'b1);
    full1("w10", 1'b1, 1'b0, 1'b1, 1'b0);
    full1("w11", 1'b1, 1'b1, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
